// File: rtl/lc3_pipeline_control.sv
// LC3 pipeline controller: per-stage enables, branch resolution stall,
// data-memory access FSM and ALU-to-ALU operand bypass detection.
module lc3_pipeline_control #(
   parameter int CF_BUBBLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        complete_instr,
   input  logic        complete_data,
   input  logic [15:0] Imem_dout,
   input  logic [15:0] IR,
   input  logic [15:0] IR_Exec,
   input  logic [2:0]  NZP,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2,
   output logic [1:0]  mem_state
);

   localparam int CW = $clog2(CF_BUBBLES + 1);
   localparam logic [CW-1:0] CF_LOAD = CW'(CF_BUBBLES);
   localparam logic [CW-1:0] CF_ONE  = CW'(1);

   localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                          OP_ST  = 4'b0011, OP_AND = 4'b0101, OP_LDR = 4'b0110,
                          OP_STR = 4'b0111, OP_NOT = 4'b1001, OP_LDI = 4'b1010,
                          OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      MEM_READ  = 2'b00,
      MEM_IND   = 2'b01,
      MEM_WRITE = 2'b10,
      MEM_IDLE  = 2'b11
   } mem_state_t;

   mem_state_t    r_mem_state, w_mem_next;
   logic          r_is_store,  w_is_store_next;
   logic [1:0]    r_fill,      w_fill_next;
   logic [CW-1:0] r_cf_cnt,    w_cf_next;

   logic [3:0] w_op_if, w_op_id, w_op_ex;
   logic       w_ex_producer, w_id_alu, w_id_reg2, w_br_cond;
   logic       w_unused;

   assign w_op_if = Imem_dout[15:12];
   assign w_op_id = IR[15:12];
   assign w_op_ex = IR_Exec[15:12];

   assign w_ex_producer = w_op_ex inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
   assign w_id_alu      = w_op_id inside {OP_ADD, OP_AND, OP_NOT};
   assign w_id_reg2     = (w_op_id inside {OP_ADD, OP_AND}) && !IR[5];
   assign w_br_cond     = (w_op_ex == OP_JMP) ||
                          ((w_op_ex == OP_BR) && |(IR_Exec[11:9] & NZP));

   assign w_unused  = ^{Imem_dout[11:0], IR[11:9], IR[4:3], IR_Exec[8:0]};
   assign mem_state = r_mem_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_state <= MEM_IDLE;
         r_is_store  <= 1'b0;
         r_fill      <= '0;
         r_cf_cnt    <= '0;
      end else begin
         r_mem_state <= w_mem_next;
         r_is_store  <= w_is_store_next;
         r_fill      <= w_fill_next;
         r_cf_cnt    <= w_cf_next;
      end
   end

   always_comb begin
      enable_updatePC  = 1'b0;
      enable_fetch     = 1'b0;
      enable_decode    = 1'b0;
      enable_execute   = 1'b0;
      enable_writeback = 1'b0;
      br_taken         = 1'b0;
      bypass_alu_1     = 1'b0;
      bypass_alu_2     = 1'b0;
      w_mem_next       = r_mem_state;
      w_is_store_next  = r_is_store;
      w_cf_next        = r_cf_cnt;
      w_fill_next      = (r_fill == 2'd3) ? r_fill : r_fill + 2'd1;

      // Memory access freezes everything, including the branch bubble count.
      if (r_mem_state != MEM_IDLE) begin
         if (complete_data) begin
            case (r_mem_state)
               MEM_IND:   w_mem_next = r_is_store ? MEM_WRITE : MEM_READ;
               MEM_READ: begin
                  w_mem_next       = MEM_IDLE;
                  enable_writeback = 1'b1;
               end
               default:   w_mem_next = MEM_IDLE;
            endcase
         end
      end else if (r_cf_cnt != '0) begin
         enable_execute   = (r_cf_cnt == CF_LOAD);
         enable_updatePC  = (r_cf_cnt == CF_ONE);
         br_taken         = (r_cf_cnt == CF_ONE) && w_br_cond;
         enable_writeback = &r_fill;
         w_cf_next        = r_cf_cnt - CF_ONE;
      end else begin
         enable_fetch     = 1'b1;
         enable_updatePC  = complete_instr;
         enable_decode    = complete_instr && (|r_fill);
         enable_execute   = r_fill[1];
         enable_writeback = &r_fill;
         bypass_alu_1     = w_ex_producer && w_id_alu  && (IR_Exec[11:9] == IR[8:6]);
         bypass_alu_2     = w_ex_producer && w_id_reg2 && (IR_Exec[11:9] == IR[2:0]);
      end

      if (enable_decode && (w_op_if inside {OP_BR, OP_JMP}))
         w_cf_next = CF_LOAD;

      if (enable_execute) begin
         case (w_op_id)
            OP_LD, OP_LDR: w_mem_next = MEM_READ;
            OP_ST, OP_STR: w_mem_next = MEM_WRITE;
            OP_LDI: begin
               w_mem_next      = MEM_IND;
               w_is_store_next = 1'b0;
            end
            OP_STI: begin
               w_mem_next      = MEM_IND;
               w_is_store_next = 1'b1;
            end
            default: ;
         endcase
      end

      if (!rst) begin
         enable_updatePC  = 1'b0;
         enable_fetch     = 1'b0;
         enable_decode    = 1'b0;
         enable_execute   = 1'b0;
         enable_writeback = 1'b0;
         br_taken         = 1'b0;
         bypass_alu_1     = 1'b0;
         bypass_alu_2     = 1'b0;
      end
   end

endmodule

// File: tb/tb_lc3_pipeline_control.sv
// Bench for lc3_pipeline_control: directed sequences, a constant vector table
// and a randomized run against a rule-level reference model.
module tb_lc3_pipeline_control;

   localparam int CF = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        ci, cd;
   logic [15:0] imem, ir, irx;
   logic [2:0]  nzp;
   logic        o_upd, o_fet, o_dec, o_exe, o_wb, o_br, o_bp1, o_bp2;
   logic [1:0]  o_mem;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int m_fill, m_cf, m_mem;
   bit m_store;

   typedef struct {
      string       name;
      logic        ci;
      logic [15:0] ir;
      logic [15:0] irx;
      logic [9:0]  exp;
   } vec_t;

   vec_t tbl[10];

   lc3_pipeline_control #(.CF_BUBBLES(CF)) dut (
      .clk              (clk),
      .rst              (rst),
      .complete_instr   (ci),
      .complete_data    (cd),
      .Imem_dout        (imem),
      .IR               (ir),
      .IR_Exec          (irx),
      .NZP              (nzp),
      .enable_updatePC  (o_upd),
      .enable_fetch     (o_fet),
      .enable_decode    (o_dec),
      .enable_execute   (o_exe),
      .enable_writeback (o_wb),
      .br_taken         (o_br),
      .bypass_alu_1     (o_bp1),
      .bypass_alu_2     (o_bp2),
      .mem_state        (o_mem)
   );

   always #5 clk = ~clk;

   // vector order: updatePC fetch decode execute writeback br_taken bp1 bp2 mem_state[1:0]
   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] got;
      got = {o_upd, o_fet, o_dec, o_exe, o_wb, o_br, o_bp1, o_bp2, o_mem};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
      end
   endtask

   task automatic drive(input logic ci_, input logic cd_, input logic [15:0] imem_,
                        input logic [15:0] ir_, input logic [15:0] irx_, input logic [2:0] nzp_);
      ci = ci_; cd = cd_; imem = imem_; ir = ir_; irx = irx_; nzp = nzp_;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] model_out(input logic r, input logic ci_, input logic cd_,
                                            input logic [15:0] ir_, input logic [15:0] irx_,
                                            input logic [2:0] nzp_);
      bit   busy, quiet;
      int   opd, opx;
      logic upd, fet, dec, exe, wb, br, b1, b2;
      if (!r) return 10'b0000000011;
      busy  = (m_mem != 3);
      quiet = !busy && (m_cf == 0);
      opd   = int'(ir_[15:12]);
      opx   = int'(irx_[15:12]);
      fet = quiet;
      upd = !busy && ((m_cf == 0) ? ci_ : (m_cf == 1));
      dec = quiet && ci_ && (m_fill >= 1);
      exe = !busy && ((m_cf == 0) ? (m_fill >= 2) : (m_cf == CF));
      wb  = busy ? (m_mem == 0 && cd_) : (m_fill >= 3);
      br  = !busy && (m_cf == 1) && (opx == 12 || (opx == 0 && (irx_[11:9] & nzp_) != 3'b000));
      b1  = quiet && (opx inside {1, 5, 9, 14}) && (opd inside {1, 5, 9}) && (irx_[11:9] == ir_[8:6]);
      b2  = quiet && (opx inside {1, 5, 9, 14}) && (opd inside {1, 5}) && !ir_[5] &&
            (irx_[11:9] == ir_[2:0]);
      return {upd, fet, dec, exe, wb, br, b1, b2, 2'(m_mem)};
   endfunction

   function automatic void model_step(input logic r, input logic cd_, input logic [15:0] imem_,
                                      input logic [15:0] ir_, input logic [9:0] exp);
      int opd, opi;
      if (!r) begin
         m_fill = 0; m_cf = 0; m_mem = 3; m_store = 0;
         return;
      end
      opd = int'(ir_[15:12]);
      opi = int'(imem_[15:12]);
      if (m_mem != 3) begin
         if (cd_) m_mem = (m_mem == 1) ? (m_store ? 2 : 0) : 3;
      end else if (m_cf > 0) begin
         m_cf--;
      end
      if (exp[7] && (opi == 0 || opi == 12)) m_cf = CF;
      if (exp[6]) begin
         case (opd)
            2, 6:    m_mem = 0;
            3, 7:    m_mem = 2;
            10:      begin m_mem = 1; m_store = 0; end
            11:      begin m_mem = 1; m_store = 1; end
            default: ;
         endcase
      end
      m_fill = (m_fill < 3) ? m_fill + 1 : 3;
   endfunction

   function automatic logic [15:0] rand_instr(input bit cf_bias);
      logic [15:0] w;
      w = 16'($urandom);
      if (cf_bias && $urandom_range(0, 3) == 0)
         w[15:12] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1100;
      return w;
   endfunction

   localparam logic [9:0] ALL1 = 10'b1111100011;

   initial begin
      logic        r_;
      logic [9:0]  e;

      tbl[0] = '{"add_bp1",      1'b1, 16'h1442, 16'h1261, 10'b1111101011};
      tbl[1] = '{"add_bp12",     1'b1, 16'h1441, 16'h1261, 10'b1111101111};
      tbl[2] = '{"add_imm",      1'b1, 16'h1461, 16'h1261, 10'b1111101011};
      tbl[3] = '{"lea_src",      1'b1, 16'h1441, 16'hE200, 10'b1111101111};
      tbl[4] = '{"ld_src",       1'b1, 16'h1441, 16'h2200, 10'b1111100011};
      tbl[5] = '{"not_dst",      1'b1, 16'h9441, 16'h1261, 10'b1111101011};
      tbl[6] = '{"and_reg",      1'b1, 16'h5441, 16'h1261, 10'b1111101111};
      tbl[7] = '{"instr_stall",  1'b0, 16'h1441, 16'h1261, 10'b0101101111};
      tbl[8] = '{"no_match",     1'b1, 16'h1082, 16'h1261, 10'b1111100011};
      tbl[9] = '{"not_producer", 1'b1, 16'h1441, 16'h9241, 10'b1111101111};

      // reset and pipeline fill
      rst = 1'b0;
      drive(1'b1, 1'b0, 16'h1000, 16'h1000, 16'h0000, 3'b000);
      tick(); #2; check("reset", 10'b0000000011);
      tick(); rst = 1'b1; #2; check("fill_c1", 10'b1100000011);
      tick(); #2; check("fill_c2", 10'b1110000011);
      tick(); #2; check("fill_c3", 10'b1111000011);
      tick(); #2; check("fill_c4", ALL1);
      tick(); #2; check("fill_c5", ALL1);

      // taken BR (nzp=111, Z set)
      tick(); drive(1'b1, 1'b0, 16'h0E02, 16'h1000, 16'h0000, 3'b010); #2; check("br_issue", ALL1);
      tick(); drive(1'b1, 1'b0, 16'h1000, 16'h0E02, 16'h0E02, 3'b010); #2; check("br_cf3", 10'b0001100011);
      tick(); #2; check("br_cf2", 10'b0000100011);
      tick(); #2; check("br_cf1_taken", 10'b1000110011);
      tick(); #2; check("br_resume", ALL1);

      // not-taken BRn with P set
      tick(); drive(1'b1, 1'b0, 16'h0802, 16'h1000, 16'h0000, 3'b001); #2; check("brn_issue", ALL1);
      tick(); drive(1'b1, 1'b0, 16'h1000, 16'h0802, 16'h0802, 3'b001); #2; check("brn_cf3", 10'b0001100011);
      tick(); #2; check("brn_cf2", 10'b0000100011);
      tick(); #2; check("brn_cf1", 10'b1000100011);
      tick(); #2; check("brn_resume", ALL1);

      // LDI: indirect read then read
      tick(); drive(1'b1, 1'b0, 16'h1000, 16'hA200, 16'h1000, 3'b000); #2; check("ldi_issue", ALL1);
      tick(); drive(1'b1, 1'b0, 16'h1000, 16'h1000, 16'hA200, 3'b000); #2; check("ldi_ind_wait", 10'b0000000001);
      tick(); cd = 1'b1; #2; check("ldi_ind_done", 10'b0000000001);
      tick(); cd = 1'b0; #2; check("ldi_rd_wait", 10'b0000000000);
      tick(); cd = 1'b1; #2; check("ldi_rd_done", 10'b0000100000);
      tick(); cd = 1'b0; #2; check("ldi_after", ALL1);

      // ST issued while a branch is pending, then asynchronous reset
      tick(); drive(1'b1, 1'b0, 16'h0E02, 16'h1000, 16'h0000, 3'b000); #2; check("st_br_issue", ALL1);
      tick(); drive(1'b1, 1'b0, 16'h1000, 16'h3200, 16'h0000, 3'b000); #2; check("st_cf3", 10'b0001100011);
      tick(); ir = 16'h1000; #2; check("st_wait", 10'b0000000010);
      tick(); #2; check("st_frozen", 10'b0000000010);
      #1; rst = 1'b0; #1; check("async_rst", 10'b0000000011);
      tick(); rst = 1'b1; #2; check("refill_c1", 10'b1100000011);
      tick(); tick(); tick();

      foreach (tbl[i]) begin
         drive(tbl[i].ci, 1'b0, 16'h1000, tbl[i].ir, tbl[i].irx, 3'b000);
         #2; check(tbl[i].name, tbl[i].exp);
         tick();
      end

      // randomized run against the reference model
      for (int i = 0; i < 3000; i++) begin
         r_  = (i == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
         rst = r_;
         drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 3), rand_instr(1'b1),
               rand_instr(1'b0), rand_instr(1'b1), 3'($urandom_range(0, 7)));
         #2;
         e = model_out(r_, ci, cd, ir, irx, nzp);
         check("random", e);
         model_step(r_, cd, imem, ir, e);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
